// File: rtl/comp_serializer_pkg.sv
// ============================================================================
// Module   : comp_serializer_pkg
// Brief    : Shared sizing constants and FSM encoding for comp_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package comp_serializer_pkg;

    localparam int unsigned C_N        = 20;
    localparam int unsigned C_CHAR_LEN = 7;
    localparam int unsigned C_N_LEN    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } ser_state_e;

endpackage : comp_serializer_pkg

`default_nettype wire

// File: rtl/comp_ser_match.sv
// ============================================================================
// Module   : comp_ser_match
// Brief    : Per-beat prediction/label equality check with saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp_ser_match
    import comp_serializer_pkg::*;
#(
    parameter int N        = C_N,
    parameter int CHAR_LEN = C_CHAR_LEN,
    parameter int CNT_LEN  = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                xfer,
    input  logic [CHAR_LEN-1:0] pred,
    input  logic [CHAR_LEN-1:0] label,
    output logic [CNT_LEN-1:0]  match_cnt
);

    localparam logic [CNT_LEN-1:0] C_CNT_MAX = CNT_LEN'(N);

    logic [CNT_LEN-1:0] cnt_q;
    logic [CNT_LEN-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (xfer && (pred == label) && (cnt_q < C_CNT_MAX)) begin
            cnt_d = cnt_q + CNT_LEN'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;

endmodule : comp_ser_match

`default_nettype wire

// File: rtl/comp_serializer.sv
// ============================================================================
// Module   : comp_serializer
// Brief    : Latches N argmax results and streams them one per beat over
//            valid/ready. Optional match counter under COMP_SER_MATCH_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp_serializer
    import comp_serializer_pkg::*;
#(
    parameter int N        = C_N,
    parameter int CHAR_LEN = C_CHAR_LEN,
    parameter int N_LEN    = C_N_LEN,
    parameter int CNT_LEN  = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [N*CHAR_LEN-1:0] num,
    input  logic [N*N_LEN-1:0]    q,
    input  logic [N*CHAR_LEN-1:0] label,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHAR_LEN-1:0]   out_char,
    output logic [N_LEN-1:0]      out_q,
    output logic [CHAR_LEN-1:0]   out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [CNT_LEN-1:0]    match_cnt
);

    localparam logic [CHAR_LEN-1:0] C_LAST_IDX = CHAR_LEN'(N - 1);

    ser_state_e            state_q;
    ser_state_e            state_d;
    logic [N*CHAR_LEN-1:0] num_q;
    logic [N*CHAR_LEN-1:0] num_d;
    logic [N*N_LEN-1:0]    q_q;
    logic [N*N_LEN-1:0]    q_d;
    logic [CHAR_LEN-1:0]   idx_q;
    logic [CHAR_LEN-1:0]   idx_d;
    logic                  overrun_q;
    logic                  overrun_d;

    logic                  w_capture;
    logic                  w_xfer;
    logic [CHAR_LEN-1:0]   w_sel_char;
    logic [N_LEN-1:0]      w_sel_q;

    assign w_capture = (state_q == IDLE) && run;
    assign w_xfer    = (state_q == SEND) && out_ready;

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        q_d       = q_q;
        idx_d     = idx_q;
        overrun_d = run && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (run) begin
                    num_d   = num;
                    q_d     = q;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == C_LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + CHAR_LEN'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            num_q     <= '0;
            q_q       <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            q_q       <= q_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Mux by comparison so the index never drives an out-of-range part-select
    always_comb begin
        w_sel_char = '0;
        w_sel_q    = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == CHAR_LEN'(i)) begin
                w_sel_char = num_q[i*CHAR_LEN +: CHAR_LEN];
                w_sel_q    = q_q[i*N_LEN +: N_LEN];
            end
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_char  = out_valid ? w_sel_char : '0;
    assign out_q     = out_valid ? w_sel_q    : '0;
    assign out_idx   = out_valid ? idx_q      : '0;
    assign out_last  = out_valid && (idx_q == C_LAST_IDX);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign overrun   = overrun_q;

`ifdef COMP_SER_MATCH_CNT_EN
    logic [N*CHAR_LEN-1:0] label_q;
    logic [N*CHAR_LEN-1:0] label_d;
    logic [CHAR_LEN-1:0]   w_sel_label;

    always_comb begin
        label_d = label_q;
        if (w_capture) begin
            label_d = label;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            label_q <= '0;
        end else begin
            label_q <= label_d;
        end
    end

    always_comb begin
        w_sel_label = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == CHAR_LEN'(i)) begin
                w_sel_label = label_q[i*CHAR_LEN +: CHAR_LEN];
            end
        end
    end

    comp_ser_match #(
        .N        (N),
        .CHAR_LEN (CHAR_LEN),
        .CNT_LEN  (CNT_LEN)
    ) u_match (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_capture),
        .xfer      (w_xfer),
        .pred      (w_sel_char),
        .label     (w_sel_label),
        .match_cnt (match_cnt)
    );
`else
    logic unused_label;
    logic unused_xfer;
    assign unused_label = ^label;
    assign unused_xfer  = w_xfer;
    assign match_cnt    = '0;
`endif

endmodule : comp_serializer

`default_nettype wire

// File: tb/tb_comp_serializer.sv
// ============================================================================
// Module   : tb_comp_serializer
// Brief    : Scoreboard bench for comp_serializer; random and directed streams.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comp_serializer;

    localparam int N  = 20;
    localparam int CL = 7;
    localparam int NL = 16;
    localparam int CW = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            run;
    logic [N*CL-1:0] num;
    logic [N*NL-1:0] q;
    logic [N*CL-1:0] label;
    logic            out_ready;
    logic            out_valid;
    logic [CL-1:0]   out_char;
    logic [NL-1:0]   out_q;
    logic [CL-1:0]   out_idx;
    logic            out_last;
    logic            busy;
    logic            done;
    logic            overrun;
    logic [CW-1:0]   match_cnt;

    always #5 clk = ~clk;

    comp_serializer #(.N(N), .CHAR_LEN(CL), .N_LEN(NL)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .num(num), .q(q), .label(label),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
        .out_q(out_q), .out_idx(out_idx), .out_last(out_last), .busy(busy),
        .done(done), .overrun(overrun), .match_cnt(match_cnt)
    );

    typedef struct packed {
        logic [CL-1:0] ch;
        logic [NL-1:0] sc;
        logic [CL-1:0] idx;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    xfer_cnt = 0;
    int    ovr_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a capture yields N beats in position order
    task automatic push_stream(input logic [N*CL-1:0] n, input logic [N*NL-1:0] s);
        for (int i = 0; i < N; i++) begin
            beat_t b;
            b.ch   = n[i*CL +: CL];
            b.sc   = s[i*NL +: NL];
            b.idx  = CL'(i);
            b.last = (i == N - 1);
            exp_q.push_back(b);
        end
    endtask

    function automatic int model_match(input logic [N*CL-1:0] n, input logic [N*CL-1:0] l);
        int c = 0;
`ifdef COMP_SER_MATCH_CNT_EN
        for (int i = 0; i < N; i++) if (n[i*CL +: CL] == l[i*CL +: CL]) c++;
`endif
        return c;
    endfunction

    // Monitor: pops on every transfer, checks hold during stalls
    beat_t held;
    bit    stalled = 1'b0;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            cur = '{ch: out_char, sc: out_q, idx: out_idx, last: out_last};
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_hold", 64'(cur), 64'(held));
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%0h required=none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 64'(cur), 64'(e));
                    end
                end else begin
                    stalled = 1'b1;
                    held    = cur;
                end
            end
            if (overrun) ovr_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_run();
        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // mode 0: ready high, 1: pattern 1,0,0, 2: random
    task automatic stream_until_done(input int mode, output int cyc);
        int k = 1;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (cyc >= 300) begin
                checks++;
                failures++;
                $display("FAIL done_timeout actual=%0d required<300", cyc);
                break;
            end
            tick();
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            k++;
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            num[i*CL +: CL] = CL'($urandom);
            q[i*NL +: NL]   = NL'($urandom);
            label[i*CL +: CL] = ($urandom_range(0, 1) == 1) ? num[i*CL +: CL] : CL'($urandom);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base_x;
        int base_o;
        int starts[3];
        int ns;
        bit pv;
        bit ok;

        rst_n = 1'b0; run = 1'b0; out_ready = 1'b1;
        num = '0; q = '0; label = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_char", 64'(out_char), 0);
        check("rst_out_q", 64'(out_q), 0);
        check("rst_out_idx", 64'(out_idx), 0);
        check("rst_out_last", 64'(out_last), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_overrun", 64'(overrun), 0);
        check("rst_match_cnt", 64'(match_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic stream
        for (int i = 0; i < N; i++) begin
            num[i*CL +: CL] = CL'(i);
            q[i*NL +: NL]   = NL'(16'h0100 + i);
        end
        label = '0;
        push_stream(num, q);
        pulse_run();
        stream_until_done(0, cyc);
        check("basic_done_latency", 64'(cyc), 64'd21);
        check("basic_queue_empty", 64'(exp_q.size()), 0);
        check("basic_match_cnt", 64'(match_cnt), 64'(model_match(num, label)));
        @(negedge clk);
        check("basic_done_one_cycle", 64'(done), 0);
        check("basic_idle", 64'(busy), 0);

        // Backpressure 1,0,0,...
        base_x = xfer_cnt;
        rand_data();
        push_stream(num, q);
        out_ready = 1'b1;
        pulse_run();
        stream_until_done(1, cyc);
        check("bp_queue_empty", 64'(exp_q.size()), 0);
        check("bp_transfers", 64'(xfer_cnt - base_x), 64'(N));
        out_ready = 1'b1;
        tick();

        // run arriving mid-stream at beat 5
        base_o = ovr_cnt;
        rand_data();
        push_stream(num, q);
        pulse_run();
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid && out_idx == CL'(5)) begin ok = 1'b1; break; end
        end
        check("ovr_reach_beat5", 64'(ok), 1);
        run = 1'b1;
        num = ~num;
        q   = ~q;
        tick();
        run = 1'b0;
        stream_until_done(0, cyc);
        tick();
        check("ovr_beat5_pulses", 64'(ovr_cnt - base_o), 1);
        check("ovr_beat5_queue", 64'(exp_q.size()), 0);

        // run in the DONE cycle is dropped
        base_o = ovr_cnt;
        rand_data();
        push_stream(num, q);
        pulse_run();
        stream_until_done(0, cyc);
        run = 1'b1;
        tick();
        run = 1'b0;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy) ok = 1'b0;
        end
        check("ovr_done_no_capture", 64'(ok), 1);
        check("ovr_done_pulses", 64'(ovr_cnt - base_o), 1);

        // Match count: 13 positions equal
        rand_data();
        for (int i = 0; i < N; i++)
            label[i*CL +: CL] = (i < 13) ? num[i*CL +: CL] : ~num[i*CL +: CL];
        push_stream(num, q);
        pulse_run();
        stream_until_done(2, cyc);
`ifdef COMP_SER_MATCH_CNT_EN
        check("match_13", 64'(match_cnt), 64'd13);
`else
        check("match_off_zero", 64'(match_cnt), 64'd0);
`endif
        out_ready = 1'b1;
        tick();
        rand_data();
        push_stream(num, q);
        pulse_run();
        @(negedge clk);
        check("match_clear_on_capture", 64'(match_cnt), 0);
        stream_until_done(0, cyc);
        check("match_second", 64'(match_cnt), 64'(model_match(num, label)));
        tick();

        // Async reset at beat 7
        rand_data();
        push_stream(num, q);
        pulse_run();
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid && out_idx == CL'(7)) begin ok = 1'b1; break; end
        end
        check("rst_reach_beat7", 64'(ok), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 64'({out_valid, out_char, out_q, out_idx, out_last,
                                        busy, done, overrun, match_cnt}), 0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_idle", 64'(busy), 0);
        rand_data();
        push_stream(num, q);
        pulse_run();
        stream_until_done(0, cyc);
        check("rst_restream_latency", 64'(cyc), 64'd21);
        check("rst_restream_queue", 64'(exp_q.size()), 0);
        tick();

        // run held high: capture every N+2 cycles
        base_o = ovr_cnt;
        rand_data();
        push_stream(num, q);
        push_stream(num, q);
        push_stream(num, q);
        run = 1'b1;
        ns = 0;
        cyc = 0;
        pv = 1'b0;
        while (ns < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (out_valid && !pv) begin
                starts[ns] = cyc;
                ns++;
                if (ns == 3) run = 1'b0;
            end
            pv = out_valid;
        end
        run = 1'b0;
        check("b2b_captures", 64'(ns), 3);
        if (ns == 3) begin
            check("b2b_spacing_1", 64'(starts[1] - starts[0]), 64'(N + 2));
            check("b2b_spacing_2", 64'(starts[2] - starts[1]), 64'(N + 2));
        end
        stream_until_done(0, cyc);
        tick();
        check("b2b_overruns", 64'(ovr_cnt - base_o), 64'(2 * (N + 1)));
        check("b2b_queue", 64'(exp_q.size()), 0);

        // Random streams
        for (int r = 0; r < 4; r++) begin
            rand_data();
            push_stream(num, q);
            out_ready = ($urandom_range(0, 1) == 1);
            pulse_run();
            stream_until_done(2, cyc);
            check("rand_queue", 64'(exp_q.size()), 0);
            check("rand_match", 64'(match_cnt), 64'(model_match(num, label)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_comp_serializer

`default_nettype wire

// File: doc/comp_serializer.md
# comp_serializer

Downstream stage of the comparator layer in the training datapath. Captures the N per-position argmax results (character index and its score) when the comparator layer asserts valid. Streams them out one character per cycle over a valid/ready handshake toward the loss/teacher-comparison logic. Optionally counts positions whose predicted character equals the teacher label.

## Interface
- `N`, default `` `N `` (20): sequence positions per batch
- `CHAR_LEN`, default `` `CHAR_LEN `` (7): character index width
- `N_LEN`, default `` `N_LEN `` (16): score width, signed fixed-point
- `CNT_LEN`, default `$clog2(N+1)`: match counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `run`  in  1  capture strobe, driven by the comparator layer `valid`
- `num`  in  N*CHAR_LEN  argmax indices; position i at `[i*CHAR_LEN +: CHAR_LEN]`
- `q`  in  N*N_LEN  max scores; position i at `[i*N_LEN +: N_LEN]`
- `label`  in  N*CHAR_LEN  teacher indices, same packing as `num`
- `out_valid`  out  1  `out_char`/`out_q` valid
- `out_ready`  in  1  consumer accepts
- `out_char`  out  CHAR_LEN  current position's index
- `out_q`  out  N_LEN  current position's score
- `out_idx`  out  CHAR_LEN  current position number, 0..N-1 (zero-extended)
- `out_last`  out  1  current beat is position N-1
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse after final transfer
- `overrun`  out  1  one-cycle pulse: `run` arrived while busy
- `match_cnt`  out  CNT_LEN  correct-position count (see Configuration)

## Operation
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - `run`=1 latches `num`, `q`, `label` into internal registers.
  - Clears the position counter `idx` to 0 and `match_cnt` to 0.
  - Next state is SEND.
- SEND:
  - `out_valid`=1; `out_char`/`out_q` = latched entry `idx`.
  - `out_last` = (`idx`==N-1).
  - Transfer occurs when `out_valid && out_ready`. On transfer, `idx` increments. On the transfer with `idx`==N-1, next state is DONE.
  - No transfer (`out_ready`=0): all outputs held stable; no change.
- DONE: `done`=1 for exactly one cycle, then IDLE. `match_cnt` holds its final value until the next capture.
- `run` in SEND or DONE:
  - Ignored; latched data is not disturbed.
  - `overrun` pulses for one cycle.
  - `run` in the DONE cycle is also dropped; capture is possible only from IDLE.
- `run` held high continuously: a new capture occurs on each IDLE cycle.
- Reset (async assert, any state) returns to IDLE and clears everything; no partial stream resumes.

## Timing
- Reset values: `out_valid`, `out_char`, `out_q`, `out_idx`, `out_last`, `busy`, `done`, `overrun`, `match_cnt` all 0. Internal registers and `idx` are also 0.
- `run` at cycle t: `busy`=1 and `out_valid`=1 at t+1.
- With `out_ready` tied high: N beats in cycles t+1..t+N, `done` at t+N+1, IDLE at t+N+2.
- Minimum capture-to-capture spacing: N+2 cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from `out_ready` to any output other than through state.
- `overrun` and `done` are registered pulses.

## Configuration
- `COMP_SER_MATCH_CNT_EN` defined:
  - On each transfer, `match_cnt` increments when the latched `num[idx]` equals `label[idx]`.
  - Saturates at N (cannot exceed it by construction).
  - Final value is valid from the DONE cycle.
- Not defined:
  - The `label` register and comparator are not built.
  - `match_cnt` is tied to 0.
  - `label` port stays in the interface, unused.

## Structure
- Shared constants come from `consts_train.vh` (`N`, `CHAR_LEN`, `N_LEN`). The FSM state encoding (IDLE=2'd0, SEND=2'd1, DONE=2'd2) is added there.
- One natural sub-module, `comp_ser_match`: the per-beat equality check plus counter. It is instantiated only under `COMP_SER_MATCH_CNT_EN`.
- The latch array and FSM live in the top module.

## Test plan
- Reset and basic stream:
  - Stimulus: after reset, all outputs 0. `run` pulse with `num[i]`=i, `q[i]`=16'h0100+i, `out_ready`=1.
  - Required: beats 0..19 with `out_char`=i, `out_q`=16'h0100+i, and `out_last` only on beat 19. `done` at t+21.
- Backpressure:
  - Stimulus: `out_ready` toggles 1,0,0,1,...
  - Required: outputs stable while stalled, no skipped or duplicated indices, exactly 20 transfers.
- Overrun:
  - Stimulus: `run` again at beat 5 with different data.
  - Required: `overrun` pulses once and the stream continues with the original data.
  - Stimulus: `run` in the DONE cycle.
  - Required: `overrun` pulses once and no capture occurs.
- Match count (macro on):
  - Stimulus: `label` equals `num` at 13 positions.
  - Required: `match_cnt`=13 at `done`, and it resets to 0 on the next capture.
  - Macro off: `match_cnt` stays 0.
- Async reset mid-stream:
  - Stimulus: `rst_n` low at beat 7.
  - Required: outputs 0 immediately and IDLE after release. A new `run` streams from index 0.
- Back-to-back:
  - Stimulus: `run` held high.
  - Required: captures every 22 cycles with `out_ready`=1, and `overrun` pulses on the other cycles.
